// File: rtl/acs_radix_n.sv
`default_nettype none
// ============================================================================
//  Module   : acs_radix_n
//  Purpose  : Radix-2^K add-compare-select for a Viterbi trellis state:
//             saturating sums, min-select tree (ties to lower index), valid.
//  Options  : ACS_NORM_EN adds norm_en and the NORM_VAL renormaliser.
//  Revision : 1.0 - initial release
// ============================================================================
module acs_radix_n #(
    parameter int W        = 4,
    parameter int K        = 2,
    parameter int PIPE_LVL = 0,
    parameter int NORM_VAL = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ae,
    input  logic [(2**K)*W-1:0]    acs_ppm_in,
    input  logic [(2**K)*W-1:0]    hd_in,
`ifdef ACS_NORM_EN
    input  logic                   norm_en,
`endif
    output logic [W-1:0]           acs_ppm_out,
    output logic [K-1:0]           acs_bx_out,
    output logic                   acs_vld_out
);

    localparam int            c_n   = 2**K;
    localparam int            c_lat = (PIPE_LVL != 0) ? 1 + K : 1;
    localparam logic [W-1:0]  c_inf = {W{1'b1}};

    generate
        if (NORM_VAL <= 0 || NORM_VAL >= 2**W - 1) begin : g_norm_range_err
            $error("acs_radix_n: NORM_VAL out of range");
        end
        if (PIPE_LVL != 0 && PIPE_LVL != 1) begin : g_pipe_range_err
            $error("acs_radix_n: PIPE_LVL must be 0 or 1");
        end
    endgenerate

`ifdef ACS_NORM_EN
    localparam logic [W-1:0]  c_norm = W'(NORM_VAL);
`endif

    logic [W:0]   w_add      [c_n];
    logic [W-1:0] w_sum_nxt  [c_n];
    logic [W-1:0] r_sum      [c_n];

    // Infinite metrics stay infinite; overflow clamps to infinite rather than wrapping.
    always_comb begin
        for (int i = 0; i < c_n; i++) begin
            w_add[i] = {1'b0, acs_ppm_in[i*W +: W]} + {1'b0, hd_in[i*W +: W]};
            if (acs_ppm_in[i*W +: W] == c_inf || w_add[i][W])
                w_sum_nxt[i] = c_inf;
            else
                w_sum_nxt[i] = w_add[i][W-1:0];
`ifdef ACS_NORM_EN
            if (norm_en && w_sum_nxt[i] != c_inf)
                w_sum_nxt[i] = (w_sum_nxt[i] > c_norm) ? w_sum_nxt[i] - c_norm : '0;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_n; i++) r_sum[i] <= '0;
        end else if (ae) begin
            for (int i = 0; i < c_n; i++) r_sum[i] <= w_sum_nxt[i];
        end
    end

    // Level gl halves the candidates; its select decides index bit gl-1.
    generate
        for (genvar gl = 0; gl <= K; gl++) begin : g_lvl
            localparam int c_cnt = c_n >> gl;
            logic [W-1:0] w_m [c_cnt];
            logic [K-1:0] w_i [c_cnt];

            if (gl == 0) begin : g_leaf
                always_comb begin
                    for (int j = 0; j < c_cnt; j++) begin
                        w_m[j] = r_sum[j];
                        w_i[j] = '0;
                    end
                end
            end else begin : g_cmp
                logic         w_sel [c_cnt];
                logic [W-1:0] w_cm  [c_cnt];
                logic [K-1:0] w_ci  [c_cnt];

                always_comb begin
                    for (int j = 0; j < c_cnt; j++) begin
                        w_sel[j] = g_lvl[gl-1].w_m[2*j+1] < g_lvl[gl-1].w_m[2*j];
                        w_cm[j]  = w_sel[j] ? g_lvl[gl-1].w_m[2*j+1] : g_lvl[gl-1].w_m[2*j];
                        w_ci[j]  = w_sel[j] ? g_lvl[gl-1].w_i[2*j+1] : g_lvl[gl-1].w_i[2*j];
                        w_ci[j][gl-1] = w_sel[j];
                    end
                end

                if (PIPE_LVL != 0) begin : g_reg
                    logic [W-1:0] r_m [c_cnt];
                    logic [K-1:0] r_i [c_cnt];

                    always_ff @(posedge clock or posedge reset) begin
                        if (reset) begin
                            for (int j = 0; j < c_cnt; j++) begin
                                r_m[j] <= '0;
                                r_i[j] <= '0;
                            end
                        end else begin
                            for (int j = 0; j < c_cnt; j++) begin
                                r_m[j] <= w_cm[j];
                                r_i[j] <= w_ci[j];
                            end
                        end
                    end

                    always_comb begin
                        for (int j = 0; j < c_cnt; j++) begin
                            w_m[j] = r_m[j];
                            w_i[j] = r_i[j];
                        end
                    end
                end else begin : g_comb
                    always_comb begin
                        for (int j = 0; j < c_cnt; j++) begin
                            w_m[j] = w_cm[j];
                            w_i[j] = w_ci[j];
                        end
                    end
                end
            end
        end
    endgenerate

    assign acs_ppm_out = g_lvl[K].w_m[0];
    assign acs_bx_out  = g_lvl[K].w_i[0];

    logic [c_lat-1:0] r_vld;

    generate
        if (c_lat == 1) begin : g_vld_one
            always_ff @(posedge clock or posedge reset) begin
                if (reset) r_vld <= '0;
                else       r_vld <= ae;
            end
        end else begin : g_vld_shift
            always_ff @(posedge clock or posedge reset) begin
                if (reset) r_vld <= '0;
                else       r_vld <= {r_vld[c_lat-2:0], ae};
            end
        end
    endgenerate

    assign acs_vld_out = r_vld[c_lat-1];

endmodule
`default_nettype wire

// File: tb/tb_acs_radix_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acs_radix_n
//  Purpose  : Self-checking bench for acs_radix_n; one combinational-tree and
//             one pipelined-tree instance share the same stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_acs_radix_n;

    logic        clock;
    logic        reset;
    logic        ae;
    logic [15:0] ppm;
    logic [15:0] hd;
    logic        norm_en;
    logic [3:0]  m0, m1;
    logic [1:0]  i0, i1;
    logic        v0, v1;

    int n_checks = 0;
    int n_fail   = 0;

    acs_radix_n #(.W(4), .K(2), .PIPE_LVL(0), .NORM_VAL(2)) u_dut0 (
        .clock(clock), .reset(reset), .ae(ae), .acs_ppm_in(ppm), .hd_in(hd),
`ifdef ACS_NORM_EN
        .norm_en(norm_en),
`endif
        .acs_ppm_out(m0), .acs_bx_out(i0), .acs_vld_out(v0)
    );

    acs_radix_n #(.W(4), .K(2), .PIPE_LVL(1), .NORM_VAL(2)) u_dut1 (
        .clock(clock), .reset(reset), .ae(ae), .acs_ppm_in(ppm), .hd_in(hd),
`ifdef ACS_NORM_EN
        .norm_en(norm_en),
`endif
        .acs_ppm_out(m1), .acs_bx_out(i1), .acs_vld_out(v1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] p;
        logic [15:0] h;
        logic        n;
        logic [3:0]  m;
        logic [1:0]  bx;
    } tvec_t;

    tvec_t tv[$];

    // Scoreboard indexed by the clock edge at which a sample was captured.
    logic       sb_ae [0:2047];
    logic [3:0] sb_m  [0:2047];
    logic [1:0] sb_i  [0:2047];
    int         e     = 0;
    int         rst_e = 0;
    logic [3:0] hold_m = '0;
    logic [1:0] hold_i = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, e);
        end
    endtask

    // Reference: plain per-branch arithmetic, then first-minimum linear scan.
    function automatic logic [5:0] ref_acs(input logic [15:0] p, input logic [15:0] h, input logic n);
        int best = -1;
        int bi   = 0;
        for (int b = 0; b < 4; b++) begin
            int a = int'(p[b*4 +: 4]);
            int s = (a == 15) ? 15 : a + int'(h[b*4 +: 4]);
            if (s > 15) s = 15;
            if (n && s != 15) s = (s > 2) ? s - 2 : 0;
            if (best < 0 || s < best) begin
                best = s;
                bi   = b;
            end
        end
        return {4'(best), 2'(bi)};
    endfunction

    task automatic tick(input logic a, input logic [15:0] p, input logic [15:0] h, input logic n);
        logic [5:0] r;
        logic       ev;
        ae = a; ppm = p; hd = h; norm_en = n;
        @(posedge clock);
        #1;
        e++;
        r = ref_acs(p, h, n);
        sb_ae[e] = a;
        sb_m[e]  = r[5:2];
        sb_i[e]  = r[1:0];
        if (a) begin
            hold_m = r[5:2];
            hold_i = r[1:0];
        end
        chk("p0_vld", 32'(v0), 32'(a));
        chk("p0_ppm", 32'(m0), 32'(hold_m));
        chk("p0_bx",  32'(i0), 32'(hold_i));
        ev = (e - 2 > rst_e) ? sb_ae[e-2] : 1'b0;
        chk("p1_vld", 32'(v1), 32'(ev));
        if (ev) begin
            chk("p1_ppm", 32'(m1), 32'(sb_m[e-2]));
            chk("p1_bx",  32'(i1), 32'(sb_i[e-2]));
        end
    endtask

    task automatic idle(input int cnt);
        for (int k = 0; k < cnt; k++) tick(1'b0, ppm, hd, 1'b0);
    endtask

    function automatic logic [15:0] rnd_ppm();
        logic [15:0] v;
        for (int b = 0; b < 4; b++)
            v[b*4 +: 4] = ($urandom % 6 == 0) ? 4'hF : 4'($urandom % 16);
        return v;
    endfunction

    initial begin
        // Branch 3 occupies the top nibble: {b3,b2,b1,b0}.
        tv.push_back('{{4'd7,4'd1,4'd5,4'd3},     {4'd1,4'd3,4'd0,4'd2},     1'b0, 4'd4,  2'd2});
        tv.push_back('{{4'd15,4'd4,4'd4,4'd15},   {4'd0,4'd1,4'd1,4'd0},     1'b0, 4'd5,  2'd1});
        tv.push_back('{{4'd15,4'd15,4'd15,4'd15}, {4'd0,4'd3,4'd2,4'd1},     1'b0, 4'd15, 2'd0});
        tv.push_back('{{4'd12,4'd13,4'd15,4'd14}, {4'd3,4'd2,4'd0,4'd3},     1'b0, 4'd15, 2'd0});
        tv.push_back('{{4'd2,4'd2,4'd2,4'd2},     16'h0000,                  1'b0, 4'd2,  2'd0});
        tv.push_back('{{4'd6,4'd7,4'd8,4'd9},     16'h0000,                  1'b0, 4'd6,  2'd3});
        tv.push_back('{16'h0000,                  {4'd14,4'd15,4'd15,4'd15}, 1'b0, 4'd14, 2'd3});
        tv.push_back('{{4'd3,4'd5,4'd3,4'd5},     {4'd2,4'd0,4'd2,4'd0},     1'b0, 4'd5,  2'd0});
        tv.push_back('{{4'd8,4'd1,4'd1,4'd8},     {4'd0,4'd4,4'd3,4'd0},     1'b0, 4'd4,  2'd1});
`ifdef ACS_NORM_EN
        tv.push_back('{{4'd9,4'd15,4'd1,4'd3},    16'h0000,                  1'b1, 4'd0,  2'd1});
        tv.push_back('{{4'd15,4'd15,4'd15,4'd15}, 16'h0000,                  1'b1, 4'd15, 2'd0});
        tv.push_back('{{4'd9,4'd15,4'd1,4'd15},   16'h0000,                  1'b1, 4'd0,  2'd1});
`endif

        reset = 1'b1; ae = 1'b0; ppm = '0; hd = '0; norm_en = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_p0_ppm", 32'(m0), 0); chk("rst_p0_bx", 32'(i0), 0); chk("rst_p0_vld", 32'(v0), 0);
        chk("rst_p1_ppm", 32'(m1), 0); chk("rst_p1_bx", 32'(i1), 0); chk("rst_p1_vld", 32'(v1), 0);
        @(negedge clock);
        reset = 1'b0;

        // Table vectors: single ae pulse, result next clock, valid for one clock.
        foreach (tv[t]) begin
            tick(1'b1, tv[t].p, tv[t].h, tv[t].n);
            chk("tbl_ppm", 32'(m0), 32'(tv[t].m));
            chk("tbl_bx",  32'(i0), 32'(tv[t].bx));
            tick(1'b0, tv[t].p, tv[t].h, 1'b0);
        end
        idle(3);

        // Back-to-back stream with a single bubble through the pipelined tree.
        tick(1'b1, tv[0].p, tv[0].h, 1'b0);
        tick(1'b1, tv[1].p, tv[1].h, 1'b0);
        tick(1'b0, tv[5].p, tv[5].h, 1'b0);
        tick(1'b1, tv[5].p, tv[5].h, 1'b0);
        tick(1'b1, tv[8].p, tv[8].h, 1'b0);
        idle(4);

        // Reset with two samples in flight: outputs clear without a clock edge.
        tick(1'b1, tv[0].p, tv[0].h, 1'b0);
        tick(1'b1, tv[6].p, tv[6].h, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_p0_ppm", 32'(m0), 0); chk("mid_rst_p0_vld", 32'(v0), 0);
        chk("mid_rst_p1_ppm", 32'(m1), 0); chk("mid_rst_p1_bx", 32'(i1), 0);
        chk("mid_rst_p1_vld", 32'(v1), 0);
        @(negedge clock);
        reset  = 1'b0;
        rst_e  = e;
        hold_m = '0;
        hold_i = '0;
        idle(3);
        tick(1'b1, tv[1].p, tv[1].h, 1'b0);
        idle(3);

        // Randomised traffic against the reference model.
        for (int k = 0; k < 300; k++) begin
`ifdef ACS_NORM_EN
            tick(($urandom % 4) != 0, rnd_ppm(), 16'($urandom), 1'($urandom));
`else
            tick(($urandom % 4) != 0, rnd_ppm(), 16'($urandom), 1'b0);
`endif
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
